// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI configuration space access path.
// Port indices double as the grant / last-grant encoding.
package pci_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } cfg_arb_state_t;

  localparam logic CFG_PORT_BUS = 1'b0;
  localparam logic CFG_PORT_LOC = 1'b1;

  localparam logic [31:0] CFG_TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/pci_rr_arb2.sv
// Two-way request picker: round-robin on last grant, or fixed
// priority with the bus port winning every tie.
module pci_rr_arb2
  import pci_pkg::*;
#(
  parameter bit BUS_PRIO = 1'b0
) (
  input  logic       bus_req_i,
  input  logic       loc_req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  logic bus_tie;

  assign bus_tie = BUS_PRIO || (last_i == CFG_PORT_LOC);

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (bus_req_i && loc_req_i): begin
        if (bus_tie) gnt_o[CFG_PORT_BUS] = 1'b1;
        else         gnt_o[CFG_PORT_LOC] = 1'b1;
      end
      (bus_req_i && !loc_req_i): gnt_o[CFG_PORT_BUS] = 1'b1;
      (loc_req_i && !bus_req_i): gnt_o[CFG_PORT_LOC] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pci_cfg_arb.sv
// Serialises bus and local accesses onto pci_cfg, holds the request
// until done or timeout, and returns the response to the winner.
module pci_cfg_arb
  import pci_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter bit          BUS_PRIO       = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_iswrite,
  input  logic [5:0]  bus_offset,
  input  logic [31:0] bus_write_val,
  input  logic [3:0]  bus_be,
  output logic        bus_ack,
  output logic [31:0] bus_read_val,
  output logic        bus_w_err,
  input  logic        loc_req,
  input  logic        loc_iswrite,
  input  logic [5:0]  loc_offset,
  input  logic [31:0] loc_write_val,
  input  logic [3:0]  loc_be,
  output logic        loc_ack,
  output logic [31:0] loc_read_val,
  output logic        loc_w_err,
  output logic        cfg_enable,
  output logic        cfg_iswrite,
  output logic [5:0]  cfg_offset,
  output logic [31:0] cfg_write_val,
  output logic [3:0]  cfg_be,
  input  logic [31:0] cfg_read_val,
  input  logic        cfg_done,
  input  logic        cfg_w_err,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  cfg_arb_state_t state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        iswr_q, iswr_d;
  logic [5:0]  off_q, off_d;
  logic [31:0] wval_q, wval_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] bus_rd_q, bus_rd_d;
  logic [31:0] loc_rd_q, loc_rd_d;
  logic        bus_we_q, bus_we_d;
  logic        loc_we_q, loc_we_d;
  logic [1:0]  pick;
  logic        fin;
  logic [31:0] fin_rd;
  logic        fin_we;

  pci_rr_arb2 #(
    .BUS_PRIO(BUS_PRIO)
  ) u_arb (
    .bus_req_i(bus_req),
    .loc_req_i(loc_req),
    .last_i   (last_q),
    .gnt_o    (pick)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    timer_d  = timer_q;
    tcnt_d   = tcnt_q;
    iswr_d   = iswr_q;
    off_d    = off_q;
    wval_d   = wval_q;
    be_d     = be_q;
    bus_rd_d = bus_rd_q;
    loc_rd_d = loc_rd_q;
    bus_we_d = bus_we_q;
    loc_we_d = loc_we_q;
    fin      = 1'b0;
    fin_rd   = '0;
    fin_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pick) begin
          gnt_d = pick[CFG_PORT_LOC];
          if (pick[CFG_PORT_LOC]) begin
            iswr_d = loc_iswrite;
            off_d  = loc_offset;
            wval_d = loc_write_val;
            be_d   = loc_be;
          end else begin
            iswr_d = bus_iswrite;
            off_d  = bus_offset;
            wval_d = bus_write_val;
            be_d   = bus_be;
          end
          timer_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // a real completion on the timeout edge beats the timeout
        if (cfg_done) begin
          fin    = 1'b1;
          fin_rd = cfg_read_val;
          fin_we = cfg_w_err;
        end else if (timer_q == TO_LIMIT) begin
          fin    = 1'b1;
          fin_rd = CFG_TIMEOUT_DATA;
          fin_we = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
        if (fin) begin
          state_d = RESP;
          if (gnt_q == CFG_PORT_LOC) begin
            loc_rd_d = fin_rd;
            loc_we_d = fin_we;
          end else begin
            bus_rd_d = fin_rd;
            bus_we_d = fin_we;
          end
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= CFG_PORT_BUS;
      last_q   <= CFG_PORT_LOC;
      timer_q  <= '0;
      tcnt_q   <= '0;
      iswr_q   <= 1'b0;
      off_q    <= '0;
      wval_q   <= '0;
      be_q     <= '0;
      bus_rd_q <= '0;
      loc_rd_q <= '0;
      bus_we_q <= 1'b0;
      loc_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      tcnt_q   <= tcnt_d;
      iswr_q   <= iswr_d;
      off_q    <= off_d;
      wval_q   <= wval_d;
      be_q     <= be_d;
      bus_rd_q <= bus_rd_d;
      loc_rd_q <= loc_rd_d;
      bus_we_q <= bus_we_d;
      loc_we_q <= loc_we_d;
    end
  end

  assign cfg_enable    = (state_q == BUSY);
  assign busy          = (state_q != IDLE);
  assign bus_ack       = (state_q == RESP) && (gnt_q == CFG_PORT_BUS);
  assign loc_ack       = (state_q == RESP) && (gnt_q == CFG_PORT_LOC);
  assign cfg_iswrite   = iswr_q;
  assign cfg_offset    = off_q;
  assign cfg_write_val = wval_q;
  assign cfg_be        = be_q;
  assign bus_read_val  = bus_rd_q;
  assign bus_w_err     = bus_we_q;
  assign loc_read_val  = loc_rd_q;
  assign loc_w_err     = loc_we_q;
  assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_pci_cfg_arb.sv
// Scoreboard bench for pci_cfg_arb: round-robin instance a and
// fixed-priority instance b, each with its own ack monitor.
module tb_pci_cfg_arb;

  typedef struct packed {
    logic        port;
    logic [31:0] rd;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   a_ack_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_bus_req = 0, a_bus_iswrite = 0;
  logic [5:0]  a_bus_offset = 0;
  logic [31:0] a_bus_write_val = 0;
  logic [3:0]  a_bus_be = 0;
  logic        a_loc_req = 0, a_loc_iswrite = 0;
  logic [5:0]  a_loc_offset = 0;
  logic [31:0] a_loc_write_val = 0;
  logic [3:0]  a_loc_be = 0;
  logic        a_bus_ack, a_bus_w_err, a_loc_ack, a_loc_w_err;
  logic [31:0] a_bus_read_val, a_loc_read_val;
  logic        a_cfg_enable, a_cfg_iswrite, a_busy;
  logic [5:0]  a_cfg_offset;
  logic [31:0] a_cfg_write_val, a_cfg_read_val;
  logic [3:0]  a_cfg_be;
  logic        a_cfg_done, a_cfg_w_err;
  logic [7:0]  a_timeout_cnt;
  logic        a_auto = 0, a_man_done = 0, a_man_we = 0;
  logic [31:0] a_man_rd = 0;

  assign a_cfg_done     = a_auto ? a_cfg_enable : a_man_done;
  assign a_cfg_read_val = a_auto ? {24'hA00000, 2'b00, a_cfg_offset} : a_man_rd;
  assign a_cfg_w_err    = a_auto ? 1'b0 : a_man_we;

  pci_cfg_arb #(.TIMEOUT_CYCLES(15), .BUS_PRIO(1'b0)) dut_a (
    .clk(clk), .rst(rst),
    .bus_req(a_bus_req), .bus_iswrite(a_bus_iswrite),
    .bus_offset(a_bus_offset), .bus_write_val(a_bus_write_val),
    .bus_be(a_bus_be), .bus_ack(a_bus_ack),
    .bus_read_val(a_bus_read_val), .bus_w_err(a_bus_w_err),
    .loc_req(a_loc_req), .loc_iswrite(a_loc_iswrite),
    .loc_offset(a_loc_offset), .loc_write_val(a_loc_write_val),
    .loc_be(a_loc_be), .loc_ack(a_loc_ack),
    .loc_read_val(a_loc_read_val), .loc_w_err(a_loc_w_err),
    .cfg_enable(a_cfg_enable), .cfg_iswrite(a_cfg_iswrite),
    .cfg_offset(a_cfg_offset), .cfg_write_val(a_cfg_write_val),
    .cfg_be(a_cfg_be), .cfg_read_val(a_cfg_read_val),
    .cfg_done(a_cfg_done), .cfg_w_err(a_cfg_w_err),
    .busy(a_busy), .timeout_cnt(a_timeout_cnt)
  );

  logic        b_bus_req = 0, b_loc_req = 0, b_zero = 0;
  logic [5:0]  b_bus_offset = 6'h01, b_loc_offset = 6'h02;
  logic [31:0] b_wval = 0;
  logic [3:0]  b_be = 4'hF;
  logic        b_bus_ack, b_bus_w_err, b_loc_ack, b_loc_w_err;
  logic [31:0] b_bus_read_val, b_loc_read_val;
  logic        b_cfg_enable, b_cfg_iswrite, b_busy;
  logic [5:0]  b_cfg_offset;
  logic [31:0] b_cfg_write_val, b_cfg_read_val;
  logic [3:0]  b_cfg_be;
  logic [7:0]  b_timeout_cnt;

  assign b_cfg_read_val = {24'hA00000, 2'b00, b_cfg_offset};

  pci_cfg_arb #(.TIMEOUT_CYCLES(15), .BUS_PRIO(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .bus_req(b_bus_req), .bus_iswrite(b_zero),
    .bus_offset(b_bus_offset), .bus_write_val(b_wval),
    .bus_be(b_be), .bus_ack(b_bus_ack),
    .bus_read_val(b_bus_read_val), .bus_w_err(b_bus_w_err),
    .loc_req(b_loc_req), .loc_iswrite(b_zero),
    .loc_offset(b_loc_offset), .loc_write_val(b_wval),
    .loc_be(b_be), .loc_ack(b_loc_ack),
    .loc_read_val(b_loc_read_val), .loc_w_err(b_loc_w_err),
    .cfg_enable(b_cfg_enable), .cfg_iswrite(b_cfg_iswrite),
    .cfg_offset(b_cfg_offset), .cfg_write_val(b_cfg_write_val),
    .cfg_be(b_cfg_be), .cfg_read_val(b_cfg_read_val),
    .cfg_done(b_cfg_enable), .cfg_w_err(b_zero),
    .busy(b_busy), .timeout_cnt(b_timeout_cnt)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic [31:0] r,
                              input logic w);
    exp_t e;
    e.port = p;
    e.rd   = r;
    e.we   = w;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input int limit, input int left);
    int n = 0;
    do begin
      tick();
      n++;
    end while (q_a.size() > left && n < limit);
    if (q_a.size() > left) begin
      check("a_ack_wait", 32'(q_a.size()), 32'(left));
      q_a.delete();
    end
  endtask

  task automatic drain_b(input int limit, input int left);
    int n = 0;
    do begin
      tick();
      n++;
    end while (q_b.size() > left && n < limit);
    if (q_b.size() > left) begin
      check("b_ack_wait", 32'(q_b.size()), 32'(left));
      q_b.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_bus_ack || a_loc_ack) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_ack", 32'({a_loc_ack, a_bus_ack}), 32'd0);
      end else begin
        e = q_a.pop_front();
        check("a_ack_port", 32'({a_bus_ack, a_loc_ack}),
              32'({~e.port, e.port}));
        check("a_rdata", e.port ? a_loc_read_val : a_bus_read_val, e.rd);
        check("a_werr", 32'(e.port ? a_loc_w_err : a_bus_w_err),
              32'(e.we));
        a_ack_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_bus_ack || b_loc_ack) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_ack", 32'({b_loc_ack, b_bus_ack}), 32'd0);
      end else begin
        e = q_b.pop_front();
        check("b_ack_port", 32'({b_bus_ack, b_loc_ack}),
              32'({~e.port, e.port}));
        check("b_rdata", e.port ? b_loc_read_val : b_bus_read_val, e.rd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable", 32'(a_cfg_enable), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_tcnt", 32'(a_timeout_cnt), 0);
    check("rst_acks", 32'({a_bus_ack, a_loc_ack}), 0);
    check("rst_rdata", a_bus_read_val, 0);
    rst = 1'b0;
    tick();

    // single bus read, done one cycle after grant
    a_bus_req = 1; a_bus_offset = 6'h00;
    q_a.push_back(mk(1'b0, 32'h1234_ABCD, 1'b0));
    tick();
    check("rd_enable", 32'(a_cfg_enable), 1);
    check("rd_offset", 32'(a_cfg_offset), 32'h00);
    a_man_done = 1; a_man_rd = 32'h1234_ABCD;
    tick();
    a_man_done = 0;
    check("rd_ack", 32'({a_bus_ack, a_loc_ack}), 32'b10);
    check("rd_enable_drop", 32'(a_cfg_enable), 0);
    tick();
    a_bus_req = 0;
    check("rd_ack_one_cycle", 32'(a_bus_ack), 0);
    check("rd_hold", a_bus_read_val, 32'h1234_ABCD);
    tick();

    // local write returning a write error
    a_loc_req = 1; a_loc_iswrite = 1; a_loc_offset = 6'h0A;
    a_loc_write_val = 32'hDEAD_BEEF; a_loc_be = 4'b0011;
    q_a.push_back(mk(1'b1, 32'h0, 1'b1));
    tick();
    check("wr_fields", {a_cfg_iswrite, a_cfg_be, 21'd0, a_cfg_offset},
          {1'b1, 4'b0011, 21'd0, 6'h0A});
    check("wr_wval", a_cfg_write_val, 32'hDEAD_BEEF);
    a_man_done = 1; a_man_rd = 32'h0; a_man_we = 1;
    tick();
    a_man_done = 0; a_man_we = 0;
    tick();
    a_loc_req = 0; a_loc_iswrite = 0;
    check("wr_werr_hold", 32'(a_loc_w_err), 1);
    check("wr_bus_hold", a_bus_read_val, 32'h1234_ABCD);
    tick();

    // done arriving on the timeout edge completes normally
    a_bus_req = 1; a_bus_offset = 6'h05;
    q_a.push_back(mk(1'b0, 32'h55AA_55AA, 1'b0));
    tick();
    repeat (15) tick();
    check("coinc_no_early_ack", 32'(a_bus_ack), 0);
    a_man_done = 1; a_man_rd = 32'h55AA_55AA;
    tick();
    a_man_done = 0;
    check("coinc_ack", 32'(a_bus_ack), 1);
    tick();
    a_bus_req = 0;
    check("coinc_tcnt", 32'(a_timeout_cnt), 0);
    tick();

    // timeout: ack sixteen edges after grant
    a_bus_req = 1;
    q_a.push_back(mk(1'b0, 32'hFFFF_FFFF, 1'b1));
    tick();
    repeat (15) tick();
    check("to_not_yet", 32'({a_bus_ack, a_cfg_enable}), 32'b01);
    tick();
    check("to_ack", 32'({a_bus_ack, a_cfg_enable}), 32'b10);
    check("to_tcnt1", 32'(a_timeout_cnt), 1);

    // keep timing out until the counter saturates
    for (int i = 0; i < 299; i++) begin
      q_a.push_back(mk(1'b0, 32'hFFFF_FFFF, 1'b1));
      drain_a(40, 0);
    end
    a_bus_req = 0;
    check("to_saturate", 32'(a_timeout_cnt), 255);
    tick();

    // reset in the middle of an access
    a_bus_req = 1; a_bus_offset = 6'h04;
    a_loc_req = 1; a_loc_offset = 6'h08;
    tick();
    tick();
    check("pre_rst_busy", 32'(a_busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_enable", 32'({a_cfg_enable, a_busy}), 0);
    check("arst_tcnt", 32'(a_timeout_cnt), 0);
    check("arst_rdata", a_bus_read_val, 0);
    check("arst_werr", 32'({a_bus_w_err, a_loc_w_err}), 0);
    check("arst_cfg", 32'({a_cfg_iswrite, a_cfg_be, a_cfg_offset}), 0);
    repeat (2) tick();
    rst = 1'b0;
    a_auto = 1;
    a_ack_cyc.delete();
    q_a.push_back(mk(1'b0, 32'hA000_0004, 1'b0));
    q_a.push_back(mk(1'b1, 32'hA000_0008, 1'b0));
    q_a.push_back(mk(1'b0, 32'hA000_0004, 1'b0));
    drain_a(40, 0);
    a_bus_req = 0; a_loc_req = 0;
    check("rr_count", 32'(a_ack_cyc.size()), 3);
    if (a_ack_cyc.size() == 3) begin
      check("rr_gap1", 32'(a_ack_cyc[1] - a_ack_cyc[0]), 3);
      check("rr_gap2", 32'(a_ack_cyc[2] - a_ack_cyc[1]), 3);
    end
    repeat (3) tick();

    // fixed priority: bus wins every tie, local only when bus idles
    b_bus_req = 1; b_loc_req = 1;
    for (int i = 0; i < 4; i++)
      q_b.push_back(mk(1'b0, 32'hA000_0001, 1'b0));
    q_b.push_back(mk(1'b1, 32'hA000_0002, 1'b0));
    drain_b(40, 1);
    b_bus_req = 0;
    drain_b(20, 0);
    b_loc_req = 0;
    repeat (3) tick();
    check("a_queue_empty", 32'(q_a.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
